// File: rtl/demod_chan_sched_pkg.sv
// Shared types and the conjugate-multiply discriminator kernel used by the
// channel scheduler.
package demod_pkg;

    // One IQ sample as carried on a 32-bit input beat: [15:0] I, [31:16] Q.
    typedef struct packed {
        logic signed [15:0] q;
        logic signed [15:0] i;
    } iq16_t;

    // One product beat as emitted on the 64-bit output: [31:0] real, [63:32] imag.
    typedef struct packed {
        logic signed [31:0] imag;
        logic signed [31:0] re;
    } cplx32_t;

    typedef enum logic [0:0] {
        ARB  = 1'b0,
        XFER = 1'b1
    } sched_state_t;

    // cur * conj(prev). Each 16x16 product fits in 32 bits; the sums wrap,
    // which only matters when all four inputs are -32768 (real = 0x80000000).
    function automatic cplx32_t conj_mult(input iq16_t cur, input iq16_t prev);
        logic signed [31:0] ac;
        logic signed [31:0] bd;
        logic signed [31:0] bc;
        logic signed [31:0] ad;
        cplx32_t            r;
        ac     = 32'(cur.i) * 32'(prev.i);
        bd     = 32'(cur.q) * 32'(prev.q);
        bc     = 32'(cur.q) * 32'(prev.i);
        ad     = 32'(cur.i) * 32'(prev.q);
        r.re   = ac + bd;
        r.imag = bc - ad;
        return r;
    endfunction

endpackage

// File: rtl/demod_chan_sched_if.sv
// Bundles the multi-channel AXI-stream input, the product output stream and
// the per-channel control lines of the channel scheduler.
interface demod_chan_sched_if #(
    parameter int NUM_CH = 4,
    parameter int S_W    = 32,
    parameter int M_W    = 64,
    parameter int CH_W   = $clog2(NUM_CH)
);
    logic [NUM_CH-1:0]     s00_axis_tvalid;
    logic [NUM_CH*S_W-1:0] s00_axis_tdata;
    logic [NUM_CH-1:0]     s00_axis_tlast;
    logic [NUM_CH-1:0]     s00_axis_tready;
    logic [NUM_CH-1:0]     ch_enable;
    logic [NUM_CH-1:0]     clear_hist;
    logic                  m00_axis_tready;
    logic                  m00_axis_tvalid;
    logic                  m00_axis_tlast;
    logic [M_W-1:0]        m00_axis_tdata;
    logic [M_W/8-1:0]      m00_axis_tstrb;
    logic [CH_W-1:0]       m00_axis_tuser;
    logic [CH_W-1:0]       grant_ch;

    // Scheduler side.
    modport slave (
        input  s00_axis_tvalid, s00_axis_tdata, s00_axis_tlast,
        input  ch_enable, clear_hist, m00_axis_tready,
        output s00_axis_tready, m00_axis_tvalid, m00_axis_tlast,
        output m00_axis_tdata, m00_axis_tstrb, m00_axis_tuser, grant_ch
    );

    // Upstream decimators / downstream stage side.
    modport master (
        output s00_axis_tvalid, s00_axis_tdata, s00_axis_tlast,
        output ch_enable, clear_hist, m00_axis_tready,
        input  s00_axis_tready, m00_axis_tvalid, m00_axis_tlast,
        input  m00_axis_tdata, m00_axis_tstrb, m00_axis_tuser, grant_ch
    );
endinterface

// File: rtl/demod_chan_sched_rr_arbiter.sv
// Round-robin first-set search: scans requests starting at i_ptr and wrapping,
// reporting the first requesting channel.
module demod_rr_arbiter #(
    parameter int NUM_CH = 4,
    parameter int CH_W   = 2
) (
    input  logic [NUM_CH-1:0] i_req,
    input  logic [CH_W-1:0]   i_ptr,
    output logic              o_found,
    output logic [CH_W-1:0]   o_winner
);

    logic [CH_W-1:0] w_idx;

    // Walk i_ptr, i_ptr+1, ... mod NUM_CH and keep the first request seen.
    always_comb begin
        o_found  = 1'b0;
        o_winner = '0;
        w_idx    = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            w_idx = CH_W'((int'(i_ptr) + k) % NUM_CH);
            if (!o_found && i_req[w_idx]) begin
                o_found  = 1'b1;
                o_winner = w_idx;
            end
        end
    end

endmodule

// File: rtl/demod_chan_sched.sv
// Time-shares one conjugate-multiply FM discriminator among NUM_CH IQ streams.
// Grants are round-robin at packet granularity; each channel keeps its own
// previous-sample history; products leave on one stream tagged with tuser.
module demod_chan_sched
    import demod_pkg::*;
#(
    parameter int NUM_CH                 = 4,
    parameter int C_S00_AXIS_TDATA_WIDTH = 32,
    parameter int C_M00_AXIS_TDATA_WIDTH = 64,
    parameter int LOCK_ON_PACKET         = 1
) (
    input  logic               s00_axis_aclk,
    input  logic               s00_axis_areset,
    demod_chan_sched_if.slave  bus
);

    localparam int CH_W = $clog2(NUM_CH);

    sched_state_t                      r_state;
    logic [CH_W-1:0]                   r_grant;
    logic [CH_W-1:0]                   r_rr_ptr;
    iq16_t                             r_hist [NUM_CH];
    logic                              r_tvalid;
    logic                              r_tlast;
    logic [C_M00_AXIS_TDATA_WIDTH-1:0] r_tdata;
    logic [C_M00_AXIS_TDATA_WIDTH/8-1:0] r_tstrb;
    logic [CH_W-1:0]                   r_tuser;

    logic [NUM_CH-1:0] w_req;
    logic [NUM_CH-1:0] w_s_tready;
    logic              w_found;
    logic [CH_W-1:0]   w_winner;
    logic              w_rdy;
    logic              w_hs;
    logic              w_last;
    logic              w_leave;
    iq16_t             w_cur;
    cplx32_t           w_prod;

    // ch_enable only gates who may win a new grant; an open packet runs on.
    assign w_req = bus.s00_axis_tvalid & bus.ch_enable;

    demod_rr_arbiter #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_arb (
        .i_req    (w_req),
        .i_ptr    (r_rr_ptr),
        .o_found  (w_found),
        .o_winner (w_winner)
    );

    assign w_rdy   = (r_state == XFER) && (bus.m00_axis_tready || !r_tvalid);
    assign w_cur   = bus.s00_axis_tdata[C_S00_AXIS_TDATA_WIDTH*r_grant +: C_S00_AXIS_TDATA_WIDTH];
    assign w_hs    = w_rdy && bus.s00_axis_tvalid[r_grant];
    assign w_last  = bus.s00_axis_tlast[r_grant];
    assign w_leave = w_hs && (w_last || (LOCK_ON_PACKET == 0));
    assign w_prod  = conj_mult(w_cur, r_hist[r_grant]);

    // Only the granted channel can see ready, and never while arbitrating.
    always_comb begin
        w_s_tready          = '0;
        w_s_tready[r_grant] = w_rdy;
    end

    // Grant FSM: pick a channel in ARB, hold it through XFER until release.
    always_ff @(posedge s00_axis_aclk or posedge s00_axis_areset) begin
        if (s00_axis_areset) begin
            r_state  <= ARB;
            r_grant  <= '0;
            r_rr_ptr <= '0;
        end else begin
            case (r_state)
                ARB: begin
                    if (w_found) begin
                        r_grant <= w_winner;
                        r_state <= XFER;
                    end
                end
                XFER: begin
                    if (w_leave) begin
                        r_rr_ptr <= (r_grant == CH_W'(NUM_CH - 1)) ? '0 : r_grant + CH_W'(1);
                        r_state  <= ARB;
                    end
                end
                default: r_state <= ARB;
            endcase
        end
    end

    // Per-channel history: an accepted sample beats a simultaneous clear.
    always_ff @(posedge s00_axis_aclk or posedge s00_axis_areset) begin
        if (s00_axis_areset) begin
            for (int c = 0; c < NUM_CH; c++) r_hist[c] <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (w_hs && (r_grant == CH_W'(c))) r_hist[c] <= w_cur;
                else if (bus.clear_hist[c])         r_hist[c] <= '0;
            end
        end
    end

    // Output register: load on handshake, hold while stalled, drop once taken.
    always_ff @(posedge s00_axis_aclk or posedge s00_axis_areset) begin
        if (s00_axis_areset) begin
            r_tvalid <= 1'b0;
            r_tlast  <= 1'b0;
            r_tdata  <= '0;
            r_tstrb  <= '0;
            r_tuser  <= '0;
        end else if (w_hs) begin
            r_tvalid <= 1'b1;
            r_tlast  <= w_last;
            r_tdata  <= w_prod;
            r_tstrb  <= '1;
            r_tuser  <= r_grant;
        end else if (bus.m00_axis_tready) begin
            r_tvalid <= 1'b0;
        end
    end

    assign bus.s00_axis_tready = w_s_tready;
    assign bus.m00_axis_tvalid = r_tvalid;
    assign bus.m00_axis_tlast  = r_tlast;
    assign bus.m00_axis_tdata  = r_tdata;
    assign bus.m00_axis_tstrb  = r_tstrb;
    assign bus.m00_axis_tuser  = r_tuser;
    assign bus.grant_ch        = r_grant;

endmodule

// File: tb/tb_demod_chan_sched.sv
// Scoreboard bench for demod_chan_sched: accepted input beats push expected
// products computed from a plain-integer model; a monitor pops on output beats.
module tb_demod_chan_sched;

    localparam int NUM_CH = 4;

    typedef struct {
        logic [63:0] data;
        int          user;
        logic        last;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    demod_chan_sched_if #(.NUM_CH(NUM_CH)) bus ();

    demod_chan_sched #(.NUM_CH(NUM_CH)) dut (
        .s00_axis_aclk   (clk),
        .s00_axis_areset (rst),
        .bus             (bus)
    );

    beat_t             exp_q[$];
    beat_t             out_log[$];
    logic [31:0]       m_hist [NUM_CH];
    logic [NUM_CH-1:0] hs_pend = '0;
    int                cur_pkt = -1;
    int                errors  = 0;
    int                checks  = 0;

    // Reference: cur * conj(prev) with ordinary 32-bit integer arithmetic.
    function automatic logic [63:0] ref_prod(input logic [31:0] cur, input logic [31:0] prev);
        int a, b, c, d, re, im;
        a  = int'($signed(cur[15:0]));
        b  = int'($signed(cur[31:16]));
        c  = int'($signed(prev[15:0]));
        d  = int'($signed(prev[31:16]));
        re = a * c + b * d;
        im = b * c - a * d;
        return {im, re};
    endfunction

    function automatic logic [15:0] rnd16();
        if ($urandom_range(0, 7) == 0) return 16'h8000;
        return 16'($urandom);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting on DUT", name);
    endtask

    // Monitor/model: sample mid-cycle, check output beats, record accepted inputs.
    initial begin
        beat_t       e;
        beat_t       a;
        logic [31:0] s;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                exp_q.delete();
                for (int c = 0; c < NUM_CH; c++) m_hist[c] = '0;
                hs_pend = '0;
                cur_pkt = -1;
            end else begin
                if (bus.m00_axis_tvalid && bus.m00_axis_tready) begin
                    a.data = bus.m00_axis_tdata;
                    a.user = int'(bus.m00_axis_tuser);
                    a.last = bus.m00_axis_tlast;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL extra_output: got tuser=%0d data=%h, expected no beat", a.user, a.data);
                    end else begin
                        e = exp_q.pop_front();
                        chk("tdata", a.data, e.data);
                        chk("tuser", a.user, e.user);
                        chk("tlast", a.last, e.last);
                        chk("tstrb", bus.m00_axis_tstrb, 8'hFF);
                    end
                    out_log.push_back(a);
                end
                chk("tready_onehot", ($countones(bus.s00_axis_tready) <= 1), 1);
                for (int c = 0; c < NUM_CH; c++) begin
                    hs_pend[c] = bus.s00_axis_tvalid[c] && bus.s00_axis_tready[c];
                    if (hs_pend[c]) begin
                        s      = bus.s00_axis_tdata[32*c +: 32];
                        e.data = ref_prod(s, m_hist[c]);
                        e.user = c;
                        e.last = bus.s00_axis_tlast[c];
                        exp_q.push_back(e);
                        m_hist[c] = s;
                        if (cur_pkt >= 0) chk("pkt_lock", c, cur_pkt);
                        cur_pkt = e.last ? -1 : c;
                    end else if (bus.clear_hist[c]) begin
                        m_hist[c] = '0;
                    end
                end
            end
        end
    end

    task automatic wait_hs(input int ch);
        int  n;
        bit  done;
        n    = 0;
        done = 0;
        while (!done) begin
            @(posedge clk);
            if (hs_pend[ch]) done = 1;
            else begin
                n++;
                if (n > 300) begin
                    timeout_fail($sformatf("handshake_ch%0d", ch));
                    done = 1;
                end
            end
        end
        #1 bus.s00_axis_tvalid[ch] = 1'b0;
    endtask

    task automatic send_beat(input int ch, input logic [15:0] i, input logic [15:0] q, input logic last);
        bus.s00_axis_tdata[32*ch +: 32] = {q, i};
        bus.s00_axis_tlast[ch]          = last;
        bus.s00_axis_tvalid[ch]         = 1'b1;
        wait_hs(ch);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || bus.m00_axis_tvalid) && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 300) timeout_fail("drain");
    endtask

    task automatic check_users(input string name, input int exp_u[$]);
        chk({name, "_count"}, out_log.size(), exp_u.size());
        for (int k = 0; k < exp_u.size() && k < out_log.size(); k++)
            chk($sformatf("%s_user%0d", name, k), out_log[k].user, exp_u[k]);
    endtask

    task automatic check_idle_outputs(input string name);
        chk({name, "_tvalid"}, bus.m00_axis_tvalid, 0);
        chk({name, "_tlast"},  bus.m00_axis_tlast,  0);
        chk({name, "_tdata"},  bus.m00_axis_tdata,  0);
        chk({name, "_tstrb"},  bus.m00_axis_tstrb,  0);
        chk({name, "_tuser"},  bus.m00_axis_tuser,  0);
        chk({name, "_sready"}, bus.s00_axis_tready, 0);
        chk({name, "_grant"},  bus.grant_ch,        0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        logic [63:0] d0;
        logic [1:0]  u0;
        int          n;
        bus.s00_axis_tvalid = '0;
        bus.s00_axis_tdata  = '0;
        bus.s00_axis_tlast  = '0;
        bus.ch_enable       = '1;
        bus.clear_hist      = '0;
        bus.m00_axis_tready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        rst = 1'b0;

        // Single channel: first beat against zero history, second against the first.
        out_log.delete();
        send_beat(0, 16'd100, 16'd0, 1'b0);
        send_beat(0, 16'd0, 16'd100, 1'b1);
        drain();
        check_users("single", '{0, 0});
        if (out_log.size() == 2) begin
            chk("single_beat0", out_log[0].data, 64'h0);
            chk("single_beat1", out_log[1].data, 64'h00002710_00000000);
        end

        // One ch3 packet leaves the round-robin pointer at ch0.
        send_beat(3, 16'd3, 16'd4, 1'b1);
        drain();

        // ch0 and ch2 packets arrive together: ch0 first, then ch2.
        out_log.delete();
        fork
            begin
                for (int k = 0; k < 3; k++) send_beat(0, rnd16(), rnd16(), k == 2);
            end
            begin
                for (int k = 0; k < 3; k++) send_beat(2, rnd16(), rnd16(), k == 2);
            end
        join
        drain();
        check_users("rr_pair", '{0, 0, 0, 2, 2, 2});

        // Search now starts at ch3, so ch3 beats ch1.
        out_log.delete();
        fork
            send_beat(1, 16'd9, 16'd9, 1'b1);
            send_beat(3, 16'd3, 16'd4, 1'b1);
        join
        drain();
        check_users("rr_next", '{3, 1});

        // ch1 disabled but valid; ch3 packet with clear_hist[3] on its first handshake.
        bus.ch_enable               = 4'b0111;
        bus.ch_enable               = 4'b1101;
        out_log.delete();
        bus.s00_axis_tdata[63:32]   = {16'd7, 16'd7};
        bus.s00_axis_tlast[1]       = 1'b1;
        bus.s00_axis_tvalid[1]      = 1'b1;
        bus.s00_axis_tdata[127:96]  = {16'd2, 16'd1};
        bus.s00_axis_tlast[3]       = 1'b0;
        bus.s00_axis_tvalid[3]      = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.s00_axis_tready[3] && n < 300);
        if (n >= 300) timeout_fail("clear_hs");
        bus.clear_hist[3] = 1'b1;
        @(posedge clk);
        #1;
        bus.clear_hist[3]      = 1'b0;
        bus.s00_axis_tvalid[3] = 1'b0;
        send_beat(3, 16'd5, 16'hFFFF, 1'b1);
        drain();
        check_users("disabled", '{3, 3});
        if (out_log.size() == 2) begin
            chk("clear_old_hist", out_log[0].data, {32'd2, 32'd11});
            chk("clear_new_hist", out_log[1].data, {32'hFFFF_FFF5, 32'd3});
        end
        bus.ch_enable = '1;
        wait_hs(1);
        drain();

        // Idle clear on ch2, then the all -32768 overflow case.
        bus.clear_hist[2] = 1'b1;
        @(posedge clk);
        #1;
        bus.clear_hist[2] = 1'b0;
        out_log.delete();
        send_beat(2, 16'h8000, 16'h8000, 1'b0);
        send_beat(2, 16'h8000, 16'h8000, 1'b1);
        drain();
        chk("ovf_count", out_log.size(), 2);
        if (out_log.size() == 2) begin
            chk("ovf_beat0", out_log[0].data, 64'h0);
            chk("ovf_beat1", out_log[1].data, 64'h00000000_80000000);
        end

        // Downstream stall for 5 cycles in the middle of a 5-beat packet.
        out_log.delete();
        fork
            begin
                for (int k = 0; k < 5; k++) send_beat(0, rnd16(), rnd16(), k == 4);
            end
            begin
                n = 0;
                while (!bus.m00_axis_tvalid && n < 100) begin
                    @(posedge clk);
                    #1;
                    n++;
                end
                if (n >= 100) timeout_fail("stall_start");
                bus.m00_axis_tready = 1'b0;
                @(negedge clk);
                #1;
                d0 = bus.m00_axis_tdata;
                u0 = bus.m00_axis_tuser;
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    #1;
                    chk("stall_tvalid", bus.m00_axis_tvalid, 1);
                    chk("stall_tdata",  bus.m00_axis_tdata, d0);
                    chk("stall_tuser",  bus.m00_axis_tuser, u0);
                    chk("stall_sready", bus.s00_axis_tready, 0);
                end
                @(posedge clk);
                #1;
                bus.m00_axis_tready = 1'b1;
            end
        join
        drain();
        chk("stall_count", out_log.size(), 5);

        // Asynchronous reset in the middle of a ch0 packet.
        send_beat(0, rnd16(), rnd16(), 1'b0);
        send_beat(0, rnd16(), rnd16(), 1'b0);
        #2 rst = 1'b1;
        #1 check_idle_outputs("midreset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_log.delete();
        send_beat(0, 16'd500, 16'hFFF9, 1'b1);
        drain();
        chk("post_reset_count", out_log.size(), 1);
        if (out_log.size() == 1) chk("post_reset_zero", out_log[0].data, 64'h0);

        // Randomized traffic: all channels, random backpressure and clears.
        for (int cyc = 0; cyc < 1500; cyc++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (hs_pend[c]) bus.s00_axis_tvalid[c] = 1'b0;
                if (!bus.s00_axis_tvalid[c] && $urandom_range(0, 2) == 0) begin
                    bus.s00_axis_tdata[32*c +: 32] = {rnd16(), rnd16()};
                    bus.s00_axis_tlast[c]          = ($urandom_range(0, 2) == 0);
                    bus.s00_axis_tvalid[c]         = 1'b1;
                end
                bus.clear_hist[c] = ($urandom_range(0, 15) == 0);
            end
            bus.m00_axis_tready = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            #1;
        end

        // Flush: finish any open packet and let pending beats be accepted.
        bus.m00_axis_tready = 1'b1;
        bus.clear_hist      = '0;
        n = 0;
        while ((bus.s00_axis_tvalid != '0 || cur_pkt >= 0) && n < 1000) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (hs_pend[c]) bus.s00_axis_tvalid[c] = 1'b0;
                if (!bus.s00_axis_tvalid[c] && c == cur_pkt) begin
                    bus.s00_axis_tdata[32*c +: 32] = {rnd16(), rnd16()};
                    bus.s00_axis_tlast[c]          = 1'b1;
                    bus.s00_axis_tvalid[c]         = 1'b1;
                end
            end
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 1000) timeout_fail("flush");
        drain();
        chk("final_queue_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
